// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the arithmetic unit, the result stage and writeback.
//   in*  : upstream result channel (valid/ready, result, flags, tag, flag-update request)
//   out* : head-entry channel toward writeback (valid/ready, result, flags, tag)
// Modports:
//   master : the environment side (drives in* payload and outReady)
//   slave  : the result stage itself
interface alu_result_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5
);
    logic                  inValid;
    logic                  inReady;
    logic [DATA_WIDTH-1:0] inResult;
    logic [6:0]            inFlags;
    logic [TAG_WIDTH-1:0]  inTag;
    logic                  inUpdateFlags;

    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] outResult;
    logic [6:0]            outFlags;
    logic [TAG_WIDTH-1:0]  outTag;

    modport master (
        output inValid, inResult, inFlags, inTag, inUpdateFlags, outReady,
        input  inReady, outValid, outResult, outFlags, outTag
    );

    modport slave (
        input  inValid, inResult, inFlags, inTag, inUpdateFlags, outReady,
        output inReady, outValid, outResult, outFlags, outTag
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered output stage behind the arithmetic unit.
// Buffers up to two results (in order) and hands them to writeback over valid/ready.
// Also owns the architectural status-flag register, the sticky exception bits and a
// saturating divide-by-zero event counter.
// Ports:
//   clk, rstN    : clock, synchronous active-low reset
//   bus          : in*/out* handshake bundle (slave side)
//   flush        : drop every buffered entry
//   stickyClear  : clear sticky bits and the divide-by-zero counter
//   statusFlags  : architectural flags {div0, zero, neg, ovf, evenPar, oddPar, carry}
//   carryFlag    : statusFlags[0], carry-in for the next operation
//   stickyFlags  : {divideByZero, overflow} sticky bits
//   div0Count    : saturating count of accepted divide-by-zero results
module alu_result_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    alu_result_stage_if.slave    bus,
    input  logic                 flush,
    input  logic                 stickyClear,
    output logic [6:0]           statusFlags,
    output logic                 carryFlag,
    output logic [1:0]           stickyFlags,
    output logic [CNT_WIDTH-1:0] div0Count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [6:0]            flags;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e               state_q, state_d;
    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    logic [6:0]           status_q, status_d;
    logic [1:0]           sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    entry_t in_entry;
    logic   accept;
    logic   retire;

    assign in_entry = '{result: bus.inResult, flags: bus.inFlags, tag: bus.inTag};

    // inReady looks only at registered state, so no outReady -> inReady path exists.
    assign bus.inReady  = rstN && (state_q != StFull);
    assign bus.outValid = (state_q != StEmpty);
    assign accept       = bus.inValid && bus.inReady;
    assign retire       = bus.outValid && bus.outReady;

    assign bus.outResult = head_q.result;
    assign bus.outFlags  = head_q.flags;
    assign bus.outTag    = head_q.tag;
    assign statusFlags   = status_q;
    assign carryFlag     = status_q[0];
    assign stickyFlags   = sticky_q;
    assign div0Count     = cnt_q;

    // Occupancy and buffer next state.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    head_d  = in_entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && retire) begin
                    head_d = in_entry;
                end else if (accept) begin
                    tail_d  = in_entry;
                    state_d = StFull;
                end else if (retire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (retire) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush only empties the buffer; flag bookkeeping below still sees the accept.
        if (flush) begin
            state_d = StEmpty;
        end
    end

    // Flag register, sticky bits and counter.
    always_comb begin
        status_d = status_q;
        if (accept && bus.inUpdateFlags) begin
            status_d = bus.inFlags;
        end

        // Clear first, then OR in this cycle's events so a same-cycle event survives.
        sticky_d = stickyClear ? 2'b00 : sticky_q;
        if (accept) begin
            sticky_d = sticky_d | {bus.inFlags[6], bus.inFlags[3]};
        end

        cnt_d = stickyClear ? '0 : cnt_q;
        if (accept && bus.inFlags[6] && (cnt_d != CntMax)) begin
            cnt_d = cnt_d + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q  <= StEmpty;
            head_q   <= '0;
            tail_q   <= '0;
            status_q <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            status_q <= status_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed, table-driven bench for alu_result_stage. Each record holds the inputs for one
// cycle and the values expected just after that cycle's rising edge.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rstN;
    logic       flush;
    logic       stickyClear;
    logic [6:0] statusFlags;
    logic       carryFlag;
    logic [1:0] stickyFlags;
    logic [7:0] div0Count;

    alu_result_stage_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

    alu_result_stage #(
        .DATA_WIDTH(32),
        .TAG_WIDTH (5),
        .CNT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .bus        (bus),
        .flush      (flush),
        .stickyClear(stickyClear),
        .statusFlags(statusFlags),
        .carryFlag  (carryFlag),
        .stickyFlags(stickyFlags),
        .div0Count  (div0Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] res;
        logic [6:0]  flg;
        logic [4:0]  tag;
        logic        upd;
        logic        fl;
        logic        ordy;
        logic        sc;
        logic        ev;
        logic [31:0] er;
        logic [6:0]  ef;
        logic [4:0]  et;
        logic        eir;
        logic [6:0]  est;
        logic [1:0]  esk;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic iv, input logic [31:0] res,
                       input logic [6:0] flg, input logic [4:0] tag, input logic upd,
                       input logic fl, input logic ordy, input logic sc, input logic ev,
                       input logic [31:0] er, input logic [6:0] ef, input logic [4:0] et,
                       input logic eir, input logic [6:0] est, input logic [1:0] esk,
                       input logic [7:0] ecnt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.res = res; v.flg = flg; v.tag = tag; v.upd = upd;
        v.fl = fl; v.ordy = ordy; v.sc = sc; v.ev = ev; v.er = er; v.ef = ef; v.et = et;
        v.eir = eir; v.est = est; v.esk = esk; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [31:0] got,
                       input logic [31:0] want);
        if (got !== want) begin
            n_fail++;
            $display("FAIL v%0d %s: got %0h, want %0h", idx, name, got, want);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rstN              = v.rst;
        bus.inValid       = v.iv;
        bus.inResult      = v.res;
        bus.inFlags       = v.flg;
        bus.inTag         = v.tag;
        bus.inUpdateFlags = v.upd;
        flush             = v.fl;
        bus.outReady      = v.ordy;
        stickyClear       = v.sc;
        if (!v.rst) begin
            #1;
            chk(idx, "inReady_in_reset", {31'd0, bus.inReady}, 32'd0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        chk(idx, "outValid", {31'd0, bus.outValid}, {31'd0, v.ev});
        chk(idx, "inReady", {31'd0, bus.inReady}, {31'd0, v.eir});
        chk(idx, "statusFlags", {25'd0, statusFlags}, {25'd0, v.est});
        chk(idx, "carryFlag", {31'd0, carryFlag}, {31'd0, v.est[0]});
        chk(idx, "stickyFlags", {30'd0, stickyFlags}, {30'd0, v.esk});
        chk(idx, "div0Count", {24'd0, div0Count}, {24'd0, v.ecnt});
        if (v.ev) begin
            chk(idx, "outResult", bus.outResult, v.er);
            chk(idx, "outFlags", {25'd0, bus.outFlags}, {25'd0, v.ef});
            chk(idx, "outTag", {27'd0, bus.outTag}, {27'd0, v.et});
        end
    endtask

    initial begin
        rstN = 1'b0; bus.inValid = 1'b0; bus.inResult = '0; bus.inFlags = '0; bus.inTag = '0;
        bus.inUpdateFlags = 1'b0; flush = 1'b0; bus.outReady = 1'b0; stickyClear = 1'b0;

        //   rst iv res      flg    tag upd fl rdy sc | ev er       ef     et eir est    esk  cnt
        // Reset
        add(0, 0, 32'h0,  7'h00, 0,  0, 0, 0, 0,   0, 32'h0,  7'h00, 0, 0, 7'h00, 2'b00, 0);
        // Single result, carry visible next cycle
        add(1, 1, 32'h5,  7'h01, 1,  1, 0, 1, 0,   1, 32'h5,  7'h01, 1, 1, 7'h01, 2'b00, 0);
        add(1, 0, 32'h0,  7'h00, 0,  0, 0, 1, 0,   0, 32'h0,  7'h00, 0, 1, 7'h01, 2'b00, 0);
        // Fill while stalled: A, B accepted, C held off
        add(1, 1, 32'hA,  7'h00, 2,  0, 0, 0, 0,   1, 32'hA,  7'h00, 2, 1, 7'h01, 2'b00, 0);
        add(1, 1, 32'hB,  7'h00, 3,  0, 0, 0, 0,   1, 32'hA,  7'h00, 2, 0, 7'h01, 2'b00, 0);
        add(1, 1, 32'hC,  7'h00, 4,  0, 0, 0, 0,   1, 32'hA,  7'h00, 2, 0, 7'h01, 2'b00, 0);
        add(1, 1, 32'hC,  7'h00, 4,  0, 0, 1, 0,   1, 32'hB,  7'h00, 3, 1, 7'h01, 2'b00, 0);
        add(1, 1, 32'hC,  7'h00, 4,  0, 0, 1, 0,   1, 32'hC,  7'h00, 4, 1, 7'h01, 2'b00, 0);
        add(1, 0, 32'h0,  7'h00, 0,  0, 0, 1, 0,   0, 32'h0,  7'h00, 0, 1, 7'h01, 2'b00, 0);
        // Sticky bits and counter, then clear
        add(1, 1, 32'h30, 7'h48, 5,  1, 0, 1, 0,   1, 32'h30, 7'h48, 5, 1, 7'h48, 2'b11, 1);
        add(1, 1, 32'h31, 7'h00, 6,  0, 0, 1, 0,   1, 32'h31, 7'h00, 6, 1, 7'h48, 2'b11, 1);
        add(1, 0, 32'h0,  7'h00, 0,  0, 0, 1, 1,   0, 32'h0,  7'h00, 0, 1, 7'h48, 2'b00, 0);
        // 260 divide-by-zero accepts; counter must stop at 255
        for (int i = 1; i <= 260; i++) begin
            add(1, 1, 32'(i), 7'h40, 7, 0, 0, 1, 0, 1, 32'(i), 7'h40, 7, 1, 7'h48, 2'b10,
                (i > 255) ? 8'd255 : 8'(i));
        end
        // Clear together with a div0 accept -> count 1, sticky div0 set
        add(1, 1, 32'h100, 7'h40, 7, 0, 0, 1, 1,   1, 32'h100, 7'h40, 7, 1, 7'h48, 2'b10, 1);
        add(1, 0, 32'h0,  7'h00, 0,  0, 0, 1, 1,   0, 32'h0,  7'h00, 0, 1, 7'h48, 2'b00, 0);
        // Flush while FULL with retire; input not accepted so flags untouched
        add(1, 1, 32'h50, 7'h00, 8,  0, 0, 0, 0,   1, 32'h50, 7'h00, 8, 1, 7'h48, 2'b00, 0);
        add(1, 1, 32'h51, 7'h00, 9,  0, 0, 0, 0,   1, 32'h50, 7'h00, 8, 0, 7'h48, 2'b00, 0);
        add(1, 1, 32'h52, 7'h49, 10, 1, 1, 1, 0,   0, 32'h0,  7'h00, 0, 1, 7'h48, 2'b00, 0);
        // Flush in ONE with a concurrent accept: entry dropped, flags still updated
        add(1, 1, 32'h60, 7'h01, 11, 0, 0, 0, 0,   1, 32'h60, 7'h01, 11, 1, 7'h48, 2'b00, 0);
        add(1, 1, 32'h61, 7'h49, 12, 1, 1, 1, 0,   0, 32'h0,  7'h00, 0, 1, 7'h49, 2'b11, 1);
        add(1, 0, 32'h0,  7'h00, 0,  0, 0, 0, 0,   0, 32'h0,  7'h00, 0, 1, 7'h49, 2'b11, 1);
        // Reset while FULL and outReady=1
        add(1, 1, 32'h70, 7'h00, 13, 0, 0, 0, 0,   1, 32'h70, 7'h00, 13, 1, 7'h49, 2'b11, 1);
        add(1, 1, 32'h71, 7'h00, 14, 0, 0, 0, 0,   1, 32'h70, 7'h00, 13, 0, 7'h49, 2'b11, 1);
        add(0, 1, 32'h72, 7'h49, 15, 1, 0, 1, 0,   0, 32'h0,  7'h00, 0, 0, 7'h00, 2'b00, 0);
        add(1, 0, 32'h0,  7'h00, 0,  0, 0, 0, 0,   0, 32'h0,  7'h00, 0, 1, 7'h00, 2'b00, 0);
        add(1, 1, 32'h80, 7'h02, 15, 1, 0, 0, 0,   1, 32'h80, 7'h02, 15, 1, 7'h02, 2'b00, 0);

        foreach (vecs[i]) begin
            apply(i, vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
